// File: rtl/mul_shift_add32_pkg.sv
// Shared definitions for the mul_shift_add32 shift-and-add multiplier:
// operand/counter widths, step count and FSM state encoding.
package mul_shift_add32_pkg;

  localparam int WIDTH     = 32;  // operand width, tied to the cla32 adder
  localparam int CNT_W     = 6;   // step counter holds 0..WIDTH
  localparam int MUL_STEPS = 32;  // one add-shift step per multiplier bit

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_shift_add32_cla32.sv
// 32-bit carry-lookahead adder: eight 4-bit groups, with group generate/
// propagate terms feeding a lookahead carry chain across the groups.
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [31:0] g;
  logic [31:0] p;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  logic [8:0]  grp_c;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Per-group generate and propagate terms.
  for (genvar i = 0; i < 8; i++) begin : g_grp
    assign grp_g[i] = g[4*i+3]
                    | (p[4*i+3] & g[4*i+2])
                    | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                    | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
    assign grp_p[i] = &p[4*i +: 4];
  end

  // Group carries from the lookahead terms, then bit carries inside each group.
  // NOTE: every variable written here gets a value on every pass first, so no latch is inferred.
  always_comb begin
    grp_c    = '0;
    c        = '0;
    grp_c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
    end
    for (int i = 0; i < 8; i++) begin
      c[4*i] = grp_c[i];
      for (int k = 0; k < 3; k++) begin
        c[4*i+k+1] = g[4*i+k] | (p[4*i+k] & c[4*i+k]);
      end
    end
    c[32] = grp_c[8];
  end

  assign s  = p ^ c[31:0];
  assign co = c[32];

endmodule

// File: rtl/mul_shift_add32.sv
// Multi-cycle 32x32 -> 64-bit unsigned shift-and-add multiplier.
// One add-shift step per clock through the cla32 adder; start/done
// handshake with the product held in DONE until cleared or restarted.
// Optional build macro EARLY_TERM_EN: finish as soon as no multiplier
// bits remain, aligning the partial product with a barrel shift.
module mul_shift_add32
  import mul_shift_add32_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_start,
  input  logic        op_clear,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        op_done,
  output logic [63:0] result
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH:0]   p_q, p_d;          // {carry, hi, lo}
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_s;
  logic               add_co;
  logic [2*WIDTH:0]   p_step;
  logic               early_hit;
  logic [2*WIDTH-1:0] early_result;

  // Add the multiplicand into the high half when the current multiplier bit is set.
  assign add_b = p_q[0] ? mcand_q : '0;

  cla32 u_cla32 (
    .a  (p_q[2*WIDTH-1:WIDTH]),
    .b  (add_b),
    .ci (1'b0),
    .s  (add_s),
    .co (add_co)
  );

  // The adder carry lands in P[64] before the shift, so it becomes bit 63.
  assign p_step = {1'b0, add_co, add_s, p_q[WIDTH-1:1]};

`ifdef EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  logic [CNT_W-1:0] rem_bits;

  // Remaining multiplier bits are lo[r-1:0] with r = 32 - count.
  assign rem_bits     = CNT_W'(MUL_STEPS) - count_q;
  assign rem_mask     = {WIDTH{1'b1}} >> count_q;
  assign early_hit    = (p_q[WIDTH-1:0] & rem_mask) == '0;
  assign early_result = p_q[2*WIDTH-1:0] >> rem_bits;
`else
  assign early_hit    = 1'b0;
  assign early_result = '0;
`endif

  // Next-state logic: clear beats start everywhere, start is ignored while executing.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    p_d      = p_q;
    count_d  = count_q;
    result_d = result_q;
    if (op_clear) begin
      state_d  = ST_IDLE;
      mcand_d  = '0;
      p_d      = '0;
      count_d  = '0;
      result_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (op_start) begin
            state_d  = ST_EXEC;
            mcand_d  = multiplicand;
            p_d      = {{(WIDTH+1){1'b0}}, multiplier};
            count_d  = '0;
            result_d = '0;
          end
        end
        ST_EXEC: begin
          if (early_hit) begin
            state_d  = ST_DONE;
            result_d = early_result;
          end else begin
            p_d     = p_step;
            count_d = count_q + 1'b1;
            if (count_q == CNT_W'(MUL_STEPS - 1)) begin
              state_d  = ST_DONE;
              result_d = p_step[2*WIDTH-1:0];
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, datapath and result registers; reset clears everything at once.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      p_q      <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      p_q      <= p_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign busy    = (state_q == ST_EXEC);
  assign op_done = (state_q == ST_DONE);
  assign result  = result_q;

endmodule
